// File: rtl/anton_neopixel_stream_loader.sv
// Loads one frame of pixel bytes from a valid/ready stream into the neopixel buffer,
// then programs the limit/ctrl registers for a single run and waits for the latch phase.
module anton_neopixel_stream_loader #(
    parameter int unsigned BUFFER_END   = 7,
    parameter int unsigned WAIT_TIMEOUT = 65535,
    parameter logic [13:0] REG_BASE     = 14'h2000
) (
    input  logic        busClk,
    input  logic        busReset,
    input  logic [7:0]  streamData,
    input  logic        streamValid,
    input  logic        streamLast,
    output logic        streamReady,
    input  logic        mode32,
    input  logic        pixelsSync,
    output logic [13:0] busAddr,
    output logic [7:0]  busDataIn,
    output logic        busWrite,
    output logic        busRead,
    output logic        busy,
    output logic        frameDone,
    output logic        errOverflow,
    output logic        errTimeout
);
    localparam int unsigned    TW       = (WAIT_TIMEOUT < 2) ? 1 : $clog2(WAIT_TIMEOUT + 1);
    localparam logic [13:0]    LAST_IDX = 14'(BUFFER_END);
    localparam logic [TW-1:0]  TMO_LOAD = TW'(WAIT_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_INIT, S_SETTLE, S_LOAD, S_MAXLO, S_MAXHI, S_START, S_WAIT_HI, S_WAIT_LO
    } state_t;

    state_t        state_q, state_d;
    logic [13:0]   cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          mode32_q, mode32_d;
    logic          sync_meta_q, sync_q;
    logic [13:0]   addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic          wr_q, wr_d;
    logic          done_q, done_d;
    logic          ovf_q, ovf_d;
    logic          tout_q, tout_d;
    logic [15:0]   max_len;

    assign max_len = {2'b00, cnt_q} - 16'd1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tmo_d    = tmo_q;
        mode32_d = mode32_q;
        ovf_d    = ovf_q;
        tout_d   = tout_q;
        wr_d     = 1'b0;
        addr_d   = '0;
        data_d   = '0;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (streamValid) begin
                    mode32_d = mode32;
                    ovf_d    = 1'b0;
                    tout_d   = 1'b0;
                    cnt_d    = '0;
                    state_d  = S_INIT;
                end
            end
            S_INIT: begin
                wr_d    = 1'b1;
                addr_d  = REG_BASE + 14'd2;
                data_d  = 8'h01;
                state_d = S_SETTLE;
            end
            // downstream drops any write on the cycle right after init
            S_SETTLE: state_d = S_LOAD;
            S_LOAD: begin
                if (streamValid) begin
                    if (cnt_q <= LAST_IDX) begin
                        wr_d   = 1'b1;
                        addr_d = {1'b0, cnt_q[12:0]};
                        data_d = streamData;
                        cnt_d  = cnt_q + 14'd1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (streamLast) state_d = S_MAXLO;
                end
            end
            S_MAXLO: begin
                wr_d    = 1'b1;
                addr_d  = REG_BASE;
                data_d  = max_len[7:0];
                state_d = S_MAXHI;
            end
            S_MAXHI: begin
                wr_d    = 1'b1;
                addr_d  = REG_BASE + 14'd1;
                data_d  = max_len[15:8];
                state_d = S_START;
            end
            S_START: begin
                wr_d    = 1'b1;
                addr_d  = REG_BASE + 14'd2;
                data_d  = {3'b000, mode32_q, 4'b0110};
                tmo_d   = TMO_LOAD;
                state_d = S_WAIT_HI;
            end
            S_WAIT_HI, S_WAIT_LO: begin
                if (state_q == S_WAIT_LO && !sync_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (tmo_q == '0) begin
                    tout_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q - TW'(1);
                    if (sync_q) state_d = S_WAIT_LO;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge busClk) begin
        if (busReset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            tmo_q       <= '0;
            mode32_q    <= 1'b0;
            sync_meta_q <= 1'b0;
            sync_q      <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            wr_q        <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            tout_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            mode32_q    <= mode32_d;
            sync_meta_q <= pixelsSync;
            sync_q      <= sync_meta_q;
            addr_q      <= addr_d;
            data_q      <= data_d;
            wr_q        <= wr_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
            tout_q      <= tout_d;
        end
    end

    assign streamReady = (state_q == S_LOAD);
    assign busy        = (state_q != S_IDLE);
    assign busAddr     = addr_q;
    assign busDataIn   = data_q;
    assign busWrite    = wr_q;
    assign busRead     = 1'b0;
    assign frameDone   = done_q;
    assign errOverflow = ovf_q;
    assign errTimeout  = tout_q;

endmodule

// File: tb/tb_anton_neopixel_stream_loader.sv
// Directed + randomized frames checked against a transaction-level model of the
// expected bus write list (address, data, cycle) and completion behaviour.
module tb_anton_neopixel_stream_loader;
    localparam int BEND = 7;
    localparam int TMO  = 20;
    localparam int REG  = 'h2000;

    logic        busClk, busReset;
    logic [7:0]  streamData;
    logic        streamValid, streamLast, streamReady, mode32, pixelsSync;
    logic [13:0] busAddr;
    logic [7:0]  busDataIn;
    logic        busWrite, busRead, busy, frameDone, errOverflow, errTimeout;

    int checks = 0, errors = 0, cyc = 0, done_cnt = 0, done_base = 0;
    int byte_q[$], acc_q[$];
    int w_a[$], w_d[$], w_s[$];
    int exp_a[$], exp_d[$], exp_s[$];

    anton_neopixel_stream_loader #(
        .BUFFER_END  (BEND),
        .WAIT_TIMEOUT(TMO),
        .REG_BASE    (14'h2000)
    ) dut (
        .busClk     (busClk),
        .busReset   (busReset),
        .streamData (streamData),
        .streamValid(streamValid),
        .streamLast (streamLast),
        .streamReady(streamReady),
        .mode32     (mode32),
        .pixelsSync (pixelsSync),
        .busAddr    (busAddr),
        .busDataIn  (busDataIn),
        .busWrite   (busWrite),
        .busRead    (busRead),
        .busy       (busy),
        .frameDone  (frameDone),
        .errOverflow(errOverflow),
        .errTimeout (errTimeout)
    );

    initial busClk = 1'b0;
    always #5 busClk = ~busClk;
    always @(posedge busClk) cyc <= cyc + 1;

    // bus/completion monitor, sampled mid-cycle
    always @(negedge busClk) begin
        if (busWrite === 1'b1) begin
            w_a.push_back(int'(busAddr));
            w_d.push_back(int'(busDataIn));
            w_s.push_back(cyc);
        end
        if (frameDone === 1'b1) done_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busWrite"}, busWrite, 0);
        chk({tag, "_busRead"}, busRead, 0);
        chk({tag, "_streamReady"}, streamReady, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_frameDone"}, frameDone, 0);
        chk({tag, "_errOverflow"}, errOverflow, 0);
        chk({tag, "_errTimeout"}, errTimeout, 0);
        chk({tag, "_busAddr"}, busAddr, 0);
        chk({tag, "_busDataIn"}, busDataIn, 0);
    endtask

    task automatic set_bytes_seq(input int n, input int base);
        byte_q.delete();
        for (int i = 0; i < n; i++) byte_q.push_back((base + i) & 255);
    endtask

    task automatic set_bytes_rand(input int n);
        byte_q.delete();
        for (int i = 0; i < n; i++) byte_q.push_back(int'($urandom_range(0, 255)));
    endtask

    // Expected write list for a frame: ctrl init, buffer bytes, max lo/hi, ctrl start.
    function automatic void build_model(input int n, input bit m32);
        int nw, mx, last;
        exp_a.delete(); exp_d.delete(); exp_s.delete();
        nw   = (n > BEND + 1) ? BEND + 1 : n;
        mx   = nw - 1;
        last = acc_q[n-1];
        exp_a.push_back(REG + 2); exp_d.push_back(1); exp_s.push_back(acc_q[0] - 1);
        for (int i = 0; i < nw; i++) begin
            exp_a.push_back(i); exp_d.push_back(byte_q[i]); exp_s.push_back(acc_q[i] + 1);
        end
        exp_a.push_back(REG);     exp_d.push_back(mx & 255);        exp_s.push_back(last + 2);
        exp_a.push_back(REG + 1); exp_d.push_back((mx >> 8) & 255); exp_s.push_back(last + 3);
        exp_a.push_back(REG + 2); exp_d.push_back(m32 ? 'h16 : 'h06); exp_s.push_back(last + 4);
    endfunction

    task automatic run_frame(input int n, input bit m32, input int gap, input int abort_at);
        int idx, hold, budget, ready_low, stop, first_seen;
        bit present;
        idx = 0; hold = 0; budget = 0; ready_low = 0; first_seen = -1;
        stop = (abort_at > 0) ? abort_at : n;
        acc_q.delete(); w_a.delete(); w_d.delete(); w_s.delete();
        done_base = done_cnt;
        while (idx < stop && budget < 400) begin
            @(negedge busClk);
            budget++;
            if (acc_q.size() > 0 && streamReady !== 1'b1) ready_low++;
            present = (hold == 0);
            if (!present) hold--;
            streamValid = present;
            streamData  = present ? 8'(byte_q[idx]) : 8'($urandom);
            streamLast  = present ? (idx == n - 1) : 1'($urandom);
            mode32      = (acc_q.size() == 0) ? m32 : 1'($urandom);
            if (present && first_seen < 0) first_seen = cyc;
            if (present && streamReady === 1'b1) begin
                if (acc_q.size() == 0)
                    chk("flags_cleared_at_start", {errOverflow, errTimeout}, 0);
                acc_q.push_back(cyc);
                idx++;
                hold = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            end
        end
        chk("load_budget", idx, stop);
        if (acc_q.size() > 0) chk("first_accept_latency", acc_q[0] - first_seen, 3);
        @(negedge busClk);
        streamValid = 1'b0;
        streamLast  = 1'b0;
        if (abort_at == 0) chk("ready_held_in_load", ready_low, 0);
    endtask

    task automatic finish_frame(input int n, input bit m32, input bit expect_tmo);
        int s, f, lat;
        bit got;
        if (acc_q.size() != n) return;
        build_model(n, m32);
        s = exp_s[exp_s.size() - 1];
        while (cyc < s + 1) @(negedge busClk);
        if (!expect_tmo) begin
            pixelsSync = 1'b1;
            repeat (4) @(negedge busClk);
            pixelsSync = 1'b0;
            f = cyc; got = 0; lat = 0;
            for (int k = 0; k < 10 && !got; k++) begin
                @(negedge busClk);
                if (frameDone === 1'b1) begin
                    got = 1;
                    lat = cyc - f;
                end
            end
            chk("done_seen", got, 1);
            chk("done_latency_2to3", (lat >= 2 && lat <= 3), 1);
            @(negedge busClk);
            chk("done_one_cycle", frameDone, 0);
            chk("busy_after_done", busy, 0);
            chk("done_count", done_cnt - done_base, 1);
        end else begin
            while (cyc < s + 19) @(negedge busClk);
            chk("tmo_not_early", errTimeout, 0);
            chk("busy_before_tmo", busy, 1);
            @(negedge busClk);
            chk("tmo_flag", errTimeout, 1);
            chk("idle_after_tmo", busy, 0);
            chk("no_done_on_tmo", frameDone, 0);
            @(negedge busClk);
            chk("no_done_count_on_tmo", done_cnt - done_base, 0);
        end
        chk("wr_count", w_a.size(), exp_a.size());
        for (int i = 0; i < exp_a.size() && i < w_a.size(); i++) begin
            chk($sformatf("wr_addr[%0d]", i), w_a[i], exp_a[i]);
            chk($sformatf("wr_data[%0d]", i), w_d[i], exp_d[i]);
            chk($sformatf("wr_cycle[%0d]", i), w_s[i], exp_s[i]);
        end
        chk("err_overflow", errOverflow, (n > BEND + 1));
        chk("err_timeout", errTimeout, expect_tmo);
    endtask

    initial begin
        int n;
        bit m;
        busReset = 1'b1; streamData = '0; streamValid = 1'b0; streamLast = 1'b0;
        mode32 = 1'b0; pixelsSync = 1'b0;
        repeat (3) @(negedge busClk);
        check_zero("reset");
        busReset = 1'b0;
        @(negedge busClk);

        set_bytes_seq(8, 'h10);
        run_frame(8, 1'b0, 0, 0);
        finish_frame(8, 1'b0, 1'b0);

        set_bytes_rand(1);
        run_frame(1, 1'b1, 0, 0);
        finish_frame(1, 1'b1, 1'b0);

        set_bytes_rand(10);
        run_frame(10, 1'b0, 0, 0);
        finish_frame(10, 1'b0, 1'b0);

        set_bytes_rand(6);
        run_frame(6, 1'b0, 2, 0);
        finish_frame(6, 1'b0, 1'b0);

        for (int r = 0; r < 4; r++) begin
            n = int'($urandom_range(1, 12));
            m = 1'($urandom);
            set_bytes_rand(n);
            run_frame(n, m, -1, 0);
            finish_frame(n, m, 1'b0);
        end

        set_bytes_rand(3);
        run_frame(3, 1'b1, 0, 0);
        finish_frame(3, 1'b1, 1'b1);

        set_bytes_seq(8, 'h10);
        run_frame(8, 1'b0, 0, 3);
        busReset = 1'b1;
        @(negedge busClk);
        check_zero("mid_reset");
        busReset = 1'b0;
        w_a.delete(); w_d.delete(); w_s.delete();
        repeat (6) @(negedge busClk);
        chk("no_wr_after_reset", w_a.size(), 0);
        chk("idle_after_reset", busy, 0);

        set_bytes_seq(8, 'h10);
        run_frame(8, 1'b0, 0, 0);
        finish_frame(8, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/anton_neopixel_stream_loader.md
# anton_neopixel_stream_loader

Upstream bus master for `anton_neopixel_raw`. It accepts one frame of pixel bytes on a valid/ready byte stream and writes the bytes into the pixel buffer over the neopixel bus. It then programs the limit and control registers to start a single non-looping transmission. It waits until the downstream block has passed through its reset/latch phase, signals frame completion, and only then accepts the next frame.

## Interface

Parameters:
- `BUFFER_END`, 7: last valid buffer byte index. Must match the downstream instance.
- `WAIT_TIMEOUT`, 65535: maximum number of busClk cycles to wait for frame completion before flagging an error.
- `REG_BASE`, 14'h2000: bus address of register 0 (max low). Register 1 is max high and register 2 is ctrl.

Ports:
- `busClk` in 1: single clock; all logic is on the rising edge.
- `busReset` in 1: synchronous, active-high reset.
- `streamData` in 8: pixel byte.
- `streamValid` in 1: byte available.
- `streamLast` in 1: qualifies the final byte of a frame.
- `streamReady` out 1: byte accepted on a cycle where valid and ready are both high.
- `mode32` in 1: selects 32-bit pixel layout. Sampled when a frame starts.
- `pixelsSync` in 1: downstream reset-phase flag from the clk7mhz domain. Asynchronous to busClk.
- `busAddr` out 14: bus address.
- `busDataIn` out 8: write data, driven into the downstream `busDataIn`.
- `busWrite` out 1: write strobe, one byte per cycle.
- `busRead` out 1: tied 0.
- `busy` out 1: high whenever state is not IDLE.
- `frameDone` out 1: one-cycle pulse when a frame completes.
- `errOverflow` out 1: the last frame had more than BUFFER_END+1 bytes. Cleared at the next frame start.
- `errTimeout` out 1: the last frame timed out waiting for completion. Cleared at the next frame start.

## Operation

- All bus outputs are registered. A bus write happens on the cycle after the state or handshake that produced it.
- IDLE:
  - `streamReady` = 0.
  - When `streamValid` = 1, latch `mode32`, clear both error flags, clear the byte counter `cnt`, and go to INIT.
- INIT: write ctrl = 8'h01 (init bit), then go to SETTLE.
- SETTLE: one cycle with no write, then go to LOAD. This gap is required because the downstream block ignores every write on the cycle after init is set.
- LOAD:
  - `streamReady` = 1.
  - Each accepted byte with `cnt` ≤ BUFFER_END produces a write of `{1'b0, cnt[12:0]}` ← `streamData`, and `cnt` increments.
  - Each accepted byte with `cnt` > BUFFER_END is dropped: no write is issued and `errOverflow` is set. `cnt` saturates.
  - An accepted byte with `streamLast` = 1 moves the FSM to MAXLO.
  - While `streamValid` = 0, no write is issued.
- MAXLO: write `REG_BASE` ← `max[7:0]`, where `max` = number of bytes written − 1 as a 16-bit value. Then go to MAXHI.
- MAXHI: write `REG_BASE+1` ← `max[15:8]`, then go to START.
- START:
  - Write `REG_BASE+2` ← `{3'b000, mode32_q, 1'b0 loop, 1'b1 run, 1'b1 limit, 1'b0 init}`. This is 8'h06 in 8-bit mode and 8'h16 in 32-bit mode.
  - Clear the timeout counter and go to WAIT_HI.
- Synchronizer: `pixelsSync` passes through a 2-flop synchronizer to give `sync_q`. Only `sync_q` is used.
- WAIT_HI: wait for `sync_q` = 1, then go to WAIT_LO.
- WAIT_LO: wait for `sync_q` = 0, then pulse `frameDone` and go to IDLE.
- Timeout:
  - The counter runs in WAIT_HI and WAIT_LO and saturates at `WAIT_TIMEOUT`.
  - On reaching `WAIT_TIMEOUT`, set `errTimeout` and go to IDLE with no `frameDone` pulse.
- Boundary conditions:
  - A single-byte frame (`streamLast` on the first byte) gives `max` = 0.
  - An overflowing frame gives `max` = BUFFER_END.
  - `cnt` is 14 bits wide. Only `cnt[BUFFER_BITS-1:0]` addresses the buffer, and bit 13 is always 0 for buffer writes.

## Timing

- State after reset: IDLE, and `busWrite`, `busRead`, `streamReady`, `busy`, `frameDone`, `errOverflow` and `errTimeout` are all 0. `busAddr` and `busDataIn` are 0.
- Reset mid-frame:
  - The FSM returns to IDLE and stops issuing writes immediately.
  - Downstream register state is not repaired; the next frame's INIT restores it.
- Throughput: one byte per cycle in LOAD. Each accepted byte has its bus write exactly 1 cycle later.
- Fixed overhead per frame:
  - INIT + SETTLE = 2 cycles.
  - MAXLO + MAXHI + START = 3 cycles.
  - Completion wait = 2 cycles of synchronizer delay plus the transmit time.
- `streamValid` in IDLE is not consumed. The first byte is accepted 2 cycles after IDLE→INIT, in the first LOAD cycle.
- `streamLast` without `streamValid` is ignored.
- `frameDone` pulses on the cycle the FSM re-enters IDLE. `busy` falls on the same edge.
- A new frame may start on the cycle after `frameDone`.

## Test plan

1. Frame of 8 bytes 8'h10..8'h17 with `mode32` = 0:
   - Bus sees writes in this order: 2002←01, one idle cycle, 0000..0007←10..17, 2000←07, 2001←00, 2002←06.
   - Driving `pixelsSync` high then low gives `frameDone` 2–3 cycles after the fall.
2. Single-byte frame with `mode32` = 1: writes 2002←01, 0000←byte, 2000←00, 2001←00, 2002←16.
3. 10-byte frame with BUFFER_END = 7:
   - Only 8 buffer writes are issued, `streamReady` stays high for all 10 bytes, and `errOverflow` = 1.
   - The max registers are written with 2000←07.
4. Stream with `streamValid` gaps (1-on/2-off):
   - No writes occur during the gaps and addresses are contiguous.
   - `streamReady` stays high in LOAD.
5. `WAIT_TIMEOUT` = 20 with `pixelsSync` held 0: `errTimeout` = 1 at 20 cycles after START, then IDLE, with no `frameDone`.
6. Reset asserted in the middle of LOAD:
   - All outputs are 0 the next cycle and no further writes occur.
   - A following frame produces the full sequence from scenario 1.
